// File: rtl/led_blink_scheduler.sv
// Round-robin LED sharer: grants one requester at a time and plays its blink burst on led_out.
// Latency: req seen in IDLE -> grant and led_out one clock later; every output is registered.
// Backpressure: req is level-held by the requester; requests wait while busy, nothing is queued.
module led_blink_scheduler #(
    parameter int                     NUM_REQ     = 4,
    parameter int                     COUNT_WIDTH = 32,
    parameter logic [COUNT_WIDTH-1:0] TICK_LIMIT  = 32'h02FAF07F,
    parameter int                     BLINK_W     = 4,
    parameter int                     GAP_TICKS   = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*BLINK_W-1:0] blink_count,
    output logic [NUM_REQ-1:0]         grant,
    output logic [NUM_REQ-1:0]         done,
    output logic                       busy,
    output logic                       led_out
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int GAP_W = $clog2(GAP_TICKS + 1);

    // S_SKIP holds the grant for one dark cycle when a zero-length burst is requested
    typedef enum logic [2:0] {
        S_IDLE,
        S_ON,
        S_OFF,
        S_GAP,
        S_SKIP,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [IDX_W-1:0]     rr_q, rr_d;
    logic [BLINK_W-1:0]   rem_q, rem_d;
    logic [GAP_W-1:0]     gap_q, gap_d;
    logic [COUNT_WIDTH-1:0] cnt_q;
    logic                 tick;
    logic                 win_found;
    logic [IDX_W-1:0]     win_idx;
    logic [BLINK_W-1:0]   win_cnt;
    logic [NUM_REQ-1:0]   grant_d;
    int                   cand;

    assign tick = (cnt_q == TICK_LIMIT);

    always_comb begin
        win_found = 1'b0;
        win_idx   = rr_q;
        cand      = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = (int'(rr_q) + i) % NUM_REQ;
            if (!win_found && req[IDX_W'(cand)]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(cand);
            end
        end
        win_cnt = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_idx == IDX_W'(i)) begin
                win_cnt = blink_count[i*BLINK_W +: BLINK_W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        rr_d    = rr_q;
        rem_d   = rem_q;
        gap_d   = gap_q;
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    idx_d   = win_idx;
                    rem_d   = win_cnt;
                    state_d = (win_cnt != '0) ? S_ON : S_SKIP;
                end
            end
            S_ON: begin
                if (tick) begin
                    rem_d = rem_q - BLINK_W'(1);
                    if (rem_q == BLINK_W'(1)) begin
                        gap_d   = '0;
                        state_d = S_GAP;
                    end else begin
                        state_d = S_OFF;
                    end
                end
            end
            S_OFF: begin
                if (tick) state_d = S_ON;
            end
            S_GAP: begin
                if (tick) begin
                    if (gap_q == GAP_W'(GAP_TICKS - 1)) state_d = S_DONE;
                    else gap_d = gap_q + GAP_W'(1);
                end
            end
            S_SKIP: state_d = S_DONE;
            S_DONE: begin
                rr_d    = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + IDX_W'(1);
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        grant_d = '0;
        if (state_d != S_IDLE) grant_d[idx_d] = 1'b1;
    end

    // Outputs are registered from next-state so they line up with the state they describe
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            rr_q    <= '0;
            rem_q   <= '0;
            gap_q   <= '0;
            cnt_q   <= '0;
            grant   <= '0;
            done    <= '0;
            busy    <= 1'b0;
            led_out <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rr_q    <= rr_d;
            rem_q   <= rem_d;
            gap_q   <= gap_d;
            if ((state_q == S_IDLE && win_found) || tick) cnt_q <= '0;
            else cnt_q <= cnt_q + COUNT_WIDTH'(1);
            grant   <= grant_d;
            done    <= (state_d == S_DONE) ? grant_d : '0;
            busy    <= (state_d != S_IDLE);
            led_out <= (state_d == S_ON);
        end
    end
endmodule

// File: tb/tb_led_blink_scheduler.sv
// Bench for led_blink_scheduler: a driver issues request batches and predicts grant order and
// burst shape into a queue; an independent monitor pops and checks each burst as it plays.
module tb_led_blink_scheduler;
    localparam int NR  = 4;
    localparam int BW  = 4;
    localparam int TL  = 3;
    localparam int GAP = 2;
    localparam int P   = TL + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [NR-1:0] req = 4'hF;
    logic [NR*BW-1:0] blink_count = '0;
    logic [NR-1:0] grant;
    logic [NR-1:0] done;
    logic          busy;
    logic          led_out;

    led_blink_scheduler #(
        .NUM_REQ    (NR),
        .COUNT_WIDTH(32),
        .TICK_LIMIT (32'd3),
        .BLINK_W    (BW),
        .GAP_TICKS  (GAP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .blink_count(blink_count),
        .grant      (grant),
        .done       (done),
        .busy       (busy),
        .led_out    (led_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int idx;
        int cnt;
        bit first;
        int issue_cyc;
    } exp_t;

    exp_t          exp_q[$];
    int            checks = 0;
    int            errors = 0;
    int            rr = 0;
    logic [NR-1:0] owed = '0;
    bit            mess = 1'b0;

    // A burst of c blinks: 2c-1 alternating phases starting lit, then GAP dark phases, then done
    function automatic bit exp_led(input int k, input int c);
        return (c > 0) && (k < (2 * c - 1) * P) && ((k / P) % 2 == 0);
    endfunction

    function automatic int burst_len(input int c);
        return (c == 0) ? 1 : (2 * c - 1 + GAP) * P;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Monitor
    bit   active = 1'b0;
    bit   post = 1'b0;
    exp_t cur;
    int   k = 0;
    int   led_bad = 0;
    int   grant_bad = 0;
    int   last_done = 0;

    always @(negedge clk) begin
        if (reset) begin
            active = 1'b0;
            post   = 1'b0;
        end else begin
            if (post) begin
                chk("release", {grant, busy}, 0);
                post = 1'b0;
            end
            if (!active && done != '0) chk("spurious_done", done, 0);
            if (!active && grant != '0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_grant", grant, 0);
                end else begin
                    cur = exp_q.pop_front();
                    chk("grant_onehot", grant, 4'b0001 << cur.idx);
                    chk("grant_latency", cyc, cur.first ? cur.issue_cyc + 1 : last_done + 2);
                    active    = 1'b1;
                    k         = 0;
                    led_bad   = 0;
                    grant_bad = 0;
                end
            end
            if (active) begin
                if (led_out !== exp_led(k, cur.cnt)) led_bad++;
                if (grant !== (4'b0001 << cur.idx) || busy !== 1'b1) grant_bad++;
                if (done != '0) begin
                    chk("done_idx", done, 4'b0001 << cur.idx);
                    chk("done_time", k, burst_len(cur.cnt));
                    chk("led_pattern", led_bad, 0);
                    chk("grant_hold", grant_bad, 0);
                    active    = 1'b0;
                    post      = 1'b1;
                    last_done = cyc;
                end else if (k > burst_len(cur.cnt) + 4) begin
                    chk("done_timeout", k, burst_len(cur.cnt));
                    active = 1'b0;
                end
                k++;
            end
        end
    end

    // Driver: requesters release on done; with mess set they may also drop req or change count early
    task automatic step();
        @(negedge clk);
        for (int i = 0; i < NR; i++) begin
            if (done[i]) begin
                req[i]  = 1'b0;
                owed[i] = 1'b0;
            end else if (mess && grant[i] && $urandom_range(0, 15) == 0) begin
                req[i] = 1'b0;
                blink_count[i*BW +: BW] = 4'($urandom);
            end
        end
    endtask

    task automatic issue(input logic [NR-1:0] mask, input logic [NR*BW-1:0] counts);
        logic [NR-1:0] pend;
        bit            first;
        int            w;
        pend  = mask;
        first = 1'b1;
        for (int i = 0; i < NR; i++)
            if (mask[i]) blink_count[i*BW +: BW] = counts[i*BW +: BW];
        req  = req | mask;
        owed = owed | mask;
        while (pend != '0) begin
            w = -1;
            for (int s = 0; s < NR; s++)
                if (w < 0 && pend[(rr + s) % NR]) w = (rr + s) % NR;
            exp_q.push_back('{w, int'(counts[w*BW +: BW]), first, cyc});
            first   = 1'b0;
            pend[w] = 1'b0;
            rr      = (w + 1) % NR;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (owed != '0 && n < 600) begin
            step();
            n++;
        end
        chk("drain", owed, 0);
        if (owed != '0) begin
            req  = '0;
            owed = '0;
        end
        step();
        step();
    endtask

    task automatic wait_grant();
        int n;
        n = 0;
        while (grant == '0 && n < 50) begin
            step();
            n++;
        end
        chk("grant_seen", grant != '0, 1);
    endtask

    task automatic do_reset();
        step();
        reset = 1'b1;
        req   = '0;
        owed  = '0;
        step();
        chk("reset_outputs", {led_out, grant, done, busy}, 0);
        step();
        reset = 1'b0;
        exp_q.delete();
        rr = 0;
    endtask

    initial begin
        logic [NR*BW-1:0] rc;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("reset_hold", {led_out, grant, done, busy}, 0);
        end
        req   = '0;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("idle_after_reset", {led_out, grant, done, busy}, 0);
        end

        issue(4'b0001, 16'h0002);
        drain();

        do_reset();
        issue(4'b0101, 16'h0101);
        drain();
        issue(4'b1001, 16'h1001);
        drain();

        issue(4'b0010, 16'h0000);
        drain();
        issue(4'b0001, 16'h000F);
        drain();

        issue(4'b0100, 16'h0300);
        wait_grant();
        repeat (5) step();
        req[2] = 1'b0;
        drain();

        issue(4'b0001, 16'h0002);
        wait_grant();
        repeat (9) step();
        do_reset();
        issue(4'b1010, 16'h1010);
        drain();

        mess = 1'b1;
        for (int r = 0; r < 15; r++) begin
            for (int i = 0; i < NR; i++) rc[i*BW +: BW] = 4'($urandom_range(0, 3));
            issue(4'($urandom_range(1, 15)), rc);
            drain();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end
endmodule
